mmu: RTL and testbench

MMU -- requirements
Module: mmu

---
 rtl/mmu.sv | 165 ++++++++++++++++
 tb/tb_mmu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu.sv
// mmu -- CPU-side memory access unit.
//   Accepts one CPU load/store at a time, checks alignment, decodes the MMIO
//   window (0x8xxx_xxxx: LED register and a free-running cycle counter) and
//   otherwise runs a held-request handshake with a word-wide RAM.
// Ports:
//   clk, reset                sync active-high reset
//   read_enable/write_enable  CPU request (write wins when both are high)
//   mem_signed_read           sign- vs zero-extension of byte/half loads
//   mem_data_width            0 byte, 1 half, 2 word, 3 reserved
//   address, data_in          byte address, right-aligned store data
//   mem_ready, data_out       one-cycle completion pulse with registered load data
//   access_error              pulses with mem_ready on misaligned/reserved accesses
//   ram_req/we/addr/wdata/wmask  RAM request, held until ram_ack
//   ram_rdata, ram_ack        RAM response
//   leds                      MMIO LED register
module mmu (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic        mem_signed_read,
  input  logic [1:0]  mem_data_width,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        mem_ready,
  output logic [31:0] data_out,
  output logic        access_error,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic [7:0]  leds
);

  localparam logic [31:0] LED_ADDR = 32'h8000_0000;
  localparam logic [31:0] CNT_ADDR = 32'h8000_0004;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] counter;
  logic [1:0]  lat_lane;
  logic [1:0]  lat_width;
  logic        lat_signed;

  logic        req;
  logic        misaligned;
  logic        is_mmio;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] mmio_rdata;

  assign req        = read_enable | write_enable;
  assign misaligned = (mem_data_width == 2'd3) ||
                      (mem_data_width == 2'd2 && address[1:0] != 2'b00) ||
                      (mem_data_width == 2'd1 && address[0]);
  assign is_mmio    = (address[31:28] == 4'h8);

  always_comb begin
    wmask = 4'b1111;
    wdata = data_in;
    case (mem_data_width)
      2'd0: begin
        wmask = 4'b0001 << address[1:0];
        wdata = {4{data_in[7:0]}};
      end
      2'd1: begin
        wmask = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    mmio_rdata = 32'h0;
    if (address == LED_ADDR)      mmio_rdata = {24'h0, leds};
    else if (address == CNT_ADDR) mmio_rdata = counter;
  end

  // Pick the addressed lane out of the RAM word and extend it.
  function automatic logic [31:0] fmt_rd(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [1:0] wid, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (wid)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (misaligned || is_mmio) ? DONE : REQ;
      REQ:     if (ram_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; every output is registered so mem_ready tracks DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter      <= 32'h0;
      mem_ready    <= 1'b0;
      access_error <= 1'b0;
      data_out     <= 32'h0;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= 30'h0;
      ram_wdata    <= 32'h0;
      ram_wmask    <= 4'h0;
      leds         <= 8'h0;
      lat_lane     <= 2'b00;
      lat_width    <= 2'b00;
      lat_signed   <= 1'b0;
    end else begin
      counter      <= counter + 32'd1;
      mem_ready    <= 1'b0;
      access_error <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (misaligned) begin
            mem_ready    <= 1'b1;
            access_error <= 1'b1;
            data_out     <= 32'h0;
          end else if (is_mmio) begin
            mem_ready <= 1'b1;
            data_out  <= write_enable ? 32'h0 : mmio_rdata;
            if (write_enable && address == LED_ADDR) leds <= data_in[7:0];
          end else begin
            ram_req    <= 1'b1;
            ram_we     <= write_enable;
            ram_addr   <= address[31:2];
            ram_wdata  <= wdata;
            ram_wmask  <= write_enable ? wmask : 4'h0;
            lat_lane   <= address[1:0];
            lat_width  <= mem_data_width;
            lat_signed <= mem_signed_read;
          end
        end
        REQ: if (ram_ack) begin
          ram_req   <= 1'b0;
          ram_we    <= 1'b0;
          mem_ready <= 1'b1;
          data_out  <= ram_we ? 32'h0 : fmt_rd(ram_rdata, lat_lane, lat_width, lat_signed);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu.sv
// tb_mmu -- directed self-checking bench for mmu with a small RAM responder
// whose ack delay and read word are chosen per vector.
module tb_mmu;
  logic        clk = 1'b0;
  logic        reset, read_enable, write_enable, mem_signed_read;
  logic [1:0]  mem_data_width;
  logic [31:0] address, data_in;
  logic        mem_ready, access_error, ram_req, ram_we, ram_ack;
  logic [31:0] data_out, ram_wdata, ram_rdata;
  logic [29:0] ram_addr;
  logic [3:0]  ram_wmask;
  logic [7:0]  leds;

  mmu dut (
    .clk(clk), .reset(reset), .read_enable(read_enable), .write_enable(write_enable),
    .mem_signed_read(mem_signed_read), .mem_data_width(mem_data_width),
    .address(address), .data_in(data_in), .mem_ready(mem_ready), .data_out(data_out),
    .access_error(access_error), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .leds(leds)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the last access.
  int          req_cycles, lat, acc_cyc;
  logic        got_err, saw_we, unstable, post_ready;
  logic [31:0] got_data, saw_wdata;
  logic [3:0]  saw_mask;
  logic [29:0] saw_addr;

  // Called #1 after a posedge with the DUT idle. lat counts the acceptance
  // cycle as cycle 1, so a RAM access acked in its first REQ cycle gives 3.
  task automatic access(input logic we, input logic re, input logic sgn, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d, input int ack_dly,
                        input logic [31:0] rdata);
    write_enable = we; read_enable = re; mem_signed_read = sgn;
    mem_data_width = w; address = a; data_in = d;
    ram_ack = 1'b0; ram_rdata = rdata;
    req_cycles = 0; lat = -1; got_err = 1'b0; got_data = 32'hx; unstable = 1'b0;
    saw_we = 1'b0; saw_mask = 4'h0; saw_wdata = 32'h0; saw_addr = 30'h0;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    write_enable = 1'b0; read_enable = 1'b0;
    for (int i = 2; i < 60; i++) begin
      if (mem_ready) begin
        lat = i; got_err = access_error; got_data = data_out;
        break;
      end
      if (ram_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          saw_we = ram_we; saw_mask = ram_wmask; saw_wdata = ram_wdata; saw_addr = ram_addr;
        end else if (ram_we !== saw_we || ram_wmask !== saw_mask ||
                     ram_wdata !== saw_wdata || ram_addr !== saw_addr) begin
          unstable = 1'b1;
        end
        ram_ack = (req_cycles - 1 == ack_dly);
      end
      @(posedge clk); #1;
      ram_ack = 1'b0;
    end
    @(posedge clk); #1;
    post_ready = mem_ready;
  endtask

  task automatic chk_ram(input string tag, input int exp_lat, input int exp_req);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_reqcyc"}, req_cycles, exp_req);
    chk({tag, "_err"}, {31'b0, got_err}, 32'h0);
    chk({tag, "_stable"}, {31'b0, unstable}, 32'h0);
    chk({tag, "_pulse"}, {31'b0, post_ready}, 32'h0);
  endtask

  logic [31:0] v1, v2;
  int          c1, c2;

  initial begin
    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0; mem_signed_read = 1'b0;
    mem_data_width = 2'd0; address = 32'h0; data_in = 32'h0;
    ram_rdata = 32'h0; ram_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_err", {31'b0, access_error}, 32'h0);
    chk("rst_dout", data_out, 32'h0);
    chk("rst_req", {31'b0, ram_req}, 32'h0);
    chk("rst_we", {31'b0, ram_we}, 32'h0);
    chk("rst_addr", {2'b0, ram_addr}, 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("rst_wmask", {28'b0, ram_wmask}, 32'h0);
    chk("rst_leds", {24'b0, leds}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Loads from RAM, acked in the first REQ cycle.
    access(0, 1, 1, 2'd0, 32'h0000_0103, 0, 0, 32'h80FF_1234);
    chk_ram("sb", 3, 1);
    chk("sb_addr", {2'b0, saw_addr}, 32'h40);
    chk("sb_we", {31'b0, saw_we}, 32'h0);
    chk("sb_data", got_data, 32'hFFFF_FF80);
    access(0, 1, 0, 2'd0, 32'h0000_0103, 0, 0, 32'h80FF_1234);
    chk("ub_data", got_data, 32'h0000_0080);
    access(0, 1, 0, 2'd0, 32'h0000_0101, 0, 0, 32'h80FF_1234);
    chk("ub1_data", got_data, 32'h0000_0012);
    access(0, 1, 1, 2'd1, 32'h0000_0002, 0, 0, 32'h80FF_1234);
    chk("sh_data", got_data, 32'hFFFF_80FF);
    access(0, 1, 1, 2'd1, 32'h0000_0000, 0, 2, 32'h80FF_1234);
    chk_ram("sh0", 5, 3);
    chk("sh0_data", got_data, 32'h0000_1234);
    access(0, 1, 1, 2'd2, 32'h0000_0008, 0, 1, 32'hDEAD_BEEF);
    chk("w_data", got_data, 32'hDEAD_BEEF);
    chk("w_addr", {2'b0, saw_addr}, 32'h2);

    // Stores to RAM.
    access(1, 0, 0, 2'd1, 32'h0000_0006, 32'h0000_ABCD, 4, 32'h0);
    chk_ram("hw", 7, 5);
    chk("hw_we", {31'b0, saw_we}, 32'h1);
    chk("hw_mask", {28'b0, saw_mask}, 32'hC);
    chk("hw_wdata", saw_wdata, 32'hABCD_ABCD);
    chk("hw_data", got_data, 32'h0);
    chk("hw_addr", {2'b0, saw_addr}, 32'h1);
    access(1, 0, 0, 2'd0, 32'h0000_0001, 32'h1234_565A, 0, 32'h0);
    chk("bw_mask", {28'b0, saw_mask}, 32'h2);
    chk("bw_wdata", saw_wdata, 32'h5A5A_5A5A);
    access(1, 0, 0, 2'd2, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'h0);
    chk("ww_mask", {28'b0, saw_mask}, 32'hF);
    chk("ww_wdata", saw_wdata, 32'hCAFE_F00D);

    // Both enables: write wins.
    access(1, 1, 0, 2'd2, 32'h0000_0010, 32'h0102_0304, 0, 32'hFFFF_FFFF);
    chk("both_we", {31'b0, saw_we}, 32'h1);
    chk("both_data", got_data, 32'h0);

    // Misaligned / reserved width: no RAM cycle, error pulse, zero data.
    access(0, 1, 0, 2'd2, 32'h0000_0002, 0, 0, 32'h1111_1111);
    chk("mw_lat", lat, 2);
    chk("mw_req", req_cycles, 0);
    chk("mw_err", {31'b0, got_err}, 32'h1);
    chk("mw_data", got_data, 32'h0);
    access(0, 1, 0, 2'd1, 32'h0000_0001, 0, 0, 32'h1111_1111);
    chk("mh_err", {31'b0, got_err}, 32'h1);
    access(1, 0, 0, 2'd3, 32'h0000_0000, 0, 0, 32'h0);
    chk("res_err", {31'b0, got_err}, 32'h1);
    chk("res_req", req_cycles, 0);

    // MMIO.
    access(1, 0, 0, 2'd0, 32'h8000_0000, 32'h0000_005A, 0, 32'h0);
    chk("led_lat", lat, 2);
    chk("led_req", req_cycles, 0);
    chk("led_val", {24'b0, leds}, 32'h5A);
    access(0, 1, 0, 2'd2, 32'h8000_0000, 0, 0, 32'h0);
    chk("led_rd", got_data, 32'h0000_005A);
    access(1, 0, 0, 2'd2, 32'h8000_0010, 32'hFFFF_FFFF, 0, 32'h0);
    chk("unm_err", {31'b0, got_err}, 32'h0);
    chk("unm_leds", {24'b0, leds}, 32'h5A);
    access(0, 1, 0, 2'd2, 32'h8000_0010, 0, 0, 32'h0);
    chk("unm_rd", got_data, 32'h0);
    access(0, 1, 0, 2'd2, 32'h8000_0004, 0, 0, 32'h0);
    v1 = got_data; c1 = acc_cyc;
    access(1, 0, 0, 2'd2, 32'h8000_0004, 32'h0, 0, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    access(0, 1, 0, 2'd2, 32'h8000_0004, 0, 0, 32'h0);
    v2 = got_data; c2 = acc_cyc;
    chk("cnt_delta", v2 - v1, 32'(c2 - c1));

    // Reset while a RAM access is in REQ.
    write_enable = 1'b1; mem_data_width = 2'd2; address = 32'h0000_0040; data_in = 32'h7;
    ram_ack = 1'b0;
    @(posedge clk); #1;
    write_enable = 1'b0;
    chk("rq_req", {31'b0, ram_req}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rq_req_drop", {31'b0, ram_req}, 32'h0);
    chk("rq_ready", {31'b0, mem_ready}, 32'h0);
    chk("rq_leds", {24'b0, leds}, 32'h0);
    v1 = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      v1 = v1 | {31'b0, mem_ready | ram_req};
    end
    chk("rq_quiet", v1, 32'h0);
    access(0, 1, 0, 2'd1, 32'h0000_0042, 0, 0, 32'hBEEF_0000);
    chk_ram("rq_after", 3, 1);
    chk("rq_after_data", got_data, 32'h0000_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
